alu32: RTL and testbench



---
 rtl/alu32.sv | 115 +++++++++++
 tb/tb_alu32.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu32.sv
// 32-bit MIPS-style execute-stage ALU: 14 ops on a/b, result and Z/C/N/V flags registered.
// Optional build macro: ALU_LUI_EN enables the LUI path on opcode 100x (otherwise it yields 0).
module alu32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);

  logic [31:0] r_d, r_q;
  logic        zero_d, zero_q;
  logic        carry_d, carry_q;
  logic        negative_d, negative_q;
  logic        overflow_d, overflow_q;

  logic [4:0]  sh;
  logic [32:0] sum, dif;
  logic [32:0] sll_w, srl_w, sra_w;
  logic        slt;

  always_comb begin
    sh    = a[4:0];
    sum   = {1'b0, a} + {1'b0, b};
    // bit 32 of the widened difference is the unsigned borrow (a < b)
    dif   = {1'b0, a} - {1'b0, b};
    slt   = $signed(a) < $signed(b);
    // Widened shifts: the extra bit catches the last bit shifted out, and is 0 for sh==0
    sll_w = {1'b0, b} << sh;
    srl_w = {b, 1'b0} >> sh;
    sra_w = $signed({b, 1'b0}) >>> sh;

    r_d        = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (aluc)
      4'b0000: begin
        r_d     = sum[31:0];
        carry_d = sum[32];
      end
      4'b0010: begin
        r_d        = sum[31:0];
        overflow_d = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'b0001: begin
        r_d     = dif[31:0];
        carry_d = dif[32];
      end
      4'b0011: begin
        r_d        = dif[31:0];
        overflow_d = (a[31] != b[31]) && (dif[31] != a[31]);
      end
      4'b0100: r_d = a & b;
      4'b0101: r_d = a | b;
      4'b0110: r_d = a ^ b;
      4'b0111: r_d = ~(a | b);
      4'b1000, 4'b1001: begin
`ifdef ALU_LUI_EN
        r_d = {b[15:0], 16'h0000};
`else
        r_d = '0;
`endif
      end
      4'b1011: r_d = {31'b0, slt};
      4'b1010: begin
        r_d     = {31'b0, dif[32]};
        carry_d = dif[32];
      end
      4'b1100: begin
        r_d     = sra_w[32:1];
        carry_d = sra_w[0];
      end
      4'b1101: begin
        r_d     = srl_w[32:1];
        carry_d = srl_w[0];
      end
      4'b1110, 4'b1111: begin
        r_d     = sll_w[31:0];
        carry_d = sll_w[32];
      end
      default: r_d = '0;
    endcase

    negative_d = (aluc == 4'b1011) ? slt : r_d[31];
    zero_d     = (r_d == 32'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      r_q        <= r_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
    end
  end

  assign r        = r_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu32.sv
// Directed bench for alu32: hand-computed vectors, flags checked as {zero,carry,negative,overflow}.
module tb_alu32;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        zero, carry, negative, overflow;

  int tests;
  int fails;

  alu32 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .aluc(aluc),
    .r(r), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] ADDU = 4'b0000, SUBU = 4'b0001, ADD = 4'b0010, SUB = 4'b0011;
  localparam logic [3:0] AND_ = 4'b0100, OR_ = 4'b0101, XOR_ = 4'b0110, NOR_ = 4'b0111;
  localparam logic [3:0] LUI0 = 4'b1000, LUI1 = 4'b1001, SLTU = 4'b1010, SLT = 4'b1011;
  localparam logic [3:0] SRA = 4'b1100, SRL = 4'b1101, SLL0 = 4'b1110, SLL1 = 4'b1111;

  // flags argument order: {zero, carry, negative, overflow}
  task automatic check(input string tag, input logic [31:0] er, input logic [3:0] ef);
    logic [35:0] obs, exp;
    obs = {r, zero, carry, negative, overflow};
    exp = {er, ef};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got r=%h zcnv=%b, want r=%h zcnv=%b", tag, obs[35:4], obs[3:0], er, ef);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    aluc = op; a = va; b = vb;
    @(posedge clk);
    #1;
    check(tag, er, ef);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; a = '0; b = '0; aluc = ADDU;
    #1;
    check("reset_state", 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    step("add_ovf",   ADD,  32'h7FFFFFFF, 32'h70000001, 32'hF0000000, 4'b0011);
    step("addu_cry",  ADDU, 32'hF2340000, 32'h80000000, 32'h72340000, 4'b0100);
    step("sub_ovf",   SUB,  32'hF00FFFFF, 32'h7FFFFFF1, 32'h7010000E, 4'b0001);
    step("subu_brw",  SUBU, 32'h7FFFFFFF, 32'hF0000001, 32'h8FFFFFFE, 4'b0110);
    step("subu_eq",   SUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000);
    step("sub_noovf", SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0010);
    step("slt",       SLT,  32'hF0001231, 32'h7AC34545, 32'h00000001, 4'b0010);
    step("sltu",      SLTU, 32'hF0001231, 32'h7AC34545, 32'h00000000, 4'b1000);
    step("sltu_lt",   SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0100);
    step("slt_ge",    SLT,  32'h00000003, 32'hFFFFFFFF, 32'h00000000, 4'b1000);
    step("sll5",      SLL0, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFE0, 4'b0110);
    step("sll_alias", SLL1, 32'h00000001, 32'h80000001, 32'h00000002, 4'b0100);
    step("sll0",      SLL0, 32'h00000000, 32'h80000001, 32'h80000001, 4'b0010);
    step("srl5",      SRL,  32'h00000005, 32'hFFFFFFFF, 32'h07FFFFFF, 4'b0100);
    step("srl_a32",   SRL,  32'hFFFFFFE0, 32'h12345678, 32'h12345678, 4'b0000);
    step("srl31",     SRL,  32'h0000001F, 32'h80000000, 32'h00000001, 4'b0000);
    step("sra3",      SRA,  32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0110);
    step("sra5",      SRA,  32'h00000005, 32'h0FFFFFFF, 32'h007FFFFF, 4'b0100);
    step("nor",       NOR_, 32'h7FFFFFFF, 32'hF0000001, 32'h00000000, 4'b1000);
    step("xor",       XOR_, 32'hA0000000, 32'h50000000, 32'hF0000000, 4'b0010);
    step("and",       AND_, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 4'b1000);
    step("or",        OR_,  32'h0000F000, 32'h00000F0F, 32'h0000FF0F, 4'b0000);
`ifdef ALU_LUI_EN
    step("lui",       LUI0, 32'hFFFFFFFF, 32'h00001234, 32'h12340000, 4'b0000);
    step("lui_alias", LUI1, 32'h00000000, 32'hABCD8765, 32'h87650000, 4'b0010);
`else
    step("lui_off",   LUI0, 32'hFFFFFFFF, 32'h00001234, 32'h00000000, 4'b1000);
    step("lui_off1",  LUI1, 32'h00000000, 32'hABCD8765, 32'h00000000, 4'b1000);
`endif

    // async reset mid-cycle while r is nonzero
    step("pre_reset", ADDU, 32'h80000000, 32'h80000005, 32'h00000005, 4'b0100);
    @(negedge clk);
    aluc = ADDU; a = 32'h00000010; b = 32'h00000020;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'h0, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_hold", 32'h0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", ADDU, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
